hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and recovery controller for the dual-issue core. It detects load-use hazards in ID and freezes the front end for a fixed number of cycles. It sequences misprediction recovery from the `recover_en`/`recover_pc` pair registered at the EX1/EX2 boundary. It drives the `stall` bubble input of the EX1/EX2 register plus the hold, flush and redirect controls of the upstream stages.

## Interface

**Parameters**
- LOAD_USE_CYCLES, default 2: number of cycles ID is held on a load-use hazard. Legal range is 1..7.

**Ports**
- clk  in  1  clock.
- rstn  in  1  reset; one clock, reset is synchronous and active-low.
- ex2_recover_en  in  1  misprediction recovery request, registered at the EX1/EX2 boundary.
- ex2_recover_pc  in  32  correct fetch PC for the recovery.
- id_rs1_1, id_rs2_1, id_rs1_2, id_rs2_2  in  5 each  source registers of the slot 1 and slot 2 instructions in ID.
- ex1_load_1, ex1_load_2  in  1 each  the slot's instruction in EX1 is a load.
- ex1_rd_1, ex1_rd_2  in  5 each  destination registers of the EX1 instructions.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold the IF/ID register.
- id_ex_bubble  out  1  load NOP into the ID/EX register.
- if_id_flush, id_ex_flush  out  1 each  clear the IF/ID and ID/EX registers.
- ex1_ex2_stall  out  1  insert NOP into EX1/EX2, both slots.
- redirect_en  out  1  force PC to redirect_pc on the next edge.
- redirect_pc  out  32  recovery target.
- stall_cycles  out  32  saturating count of load-use stall cycles.
- flush_events  out  32  saturating count of recoveries.

## Operation

**Hazard detection (`hz`, combinational)**
- `hz` is true when any nonzero ID source register equals `ex1_rd_k`, where `ex1_load_k` = 1 and `ex1_rd_k` != 0, for k = 1 or 2.

**FSM states:** RUN, LU_STALL, REDIRECT.

**RUN**
- If `ex2_recover_en`:
  - assert `ex1_ex2_stall`, `if_id_flush` and `id_ex_flush` combinationally;
  - capture `ex2_recover_pc`;
  - go to REDIRECT.
- Else if `hz`:
  - assert `pc_stall`, `if_id_stall` and `id_ex_bubble`;
  - if LOAD_USE_CYCLES > 1, load `cnt` with LOAD_USE_CYCLES-1 and go to LU_STALL;
  - otherwise remain in RUN.
- Else all controls are 0.

**LU_STALL**
- Assert `pc_stall`, `if_id_stall` and `id_ex_bubble`.
- `hz` is ignored.
- Each cycle `cnt` decrements.
- When `cnt` == 1 in this cycle, go to RUN.
- `ex2_recover_en` preempts the stall:
  - stall outputs go to 0 in that cycle;
  - the RUN-recovery actions apply;
  - `cnt` clears;
  - go to REDIRECT.

**REDIRECT** (exactly one cycle)
- Assert `redirect_en` with the captured PC.
- Assert `ex1_ex2_stall`, `if_id_flush` and `id_ex_flush`.
- `ex2_recover_en` and `hz` are ignored.
- Next state is RUN.

**Output rules**
- Flush outputs have priority over stall and hold outputs; the two sets are never asserted together.
- `redirect_pc` holds its last captured value when `redirect_en` = 0.

**Counters**
- `stall_cycles` increments each cycle `pc_stall` = 1.
- `flush_events` increments on each RUN or LU_STALL → REDIRECT transition.
- Both saturate at 0xFFFF_FFFF.

## Timing

- Reset:
  - state = RUN, `cnt` = 0, `redirect_pc` = 0, both counters = 0;
  - all control outputs = 0, including during the reset cycle (reset overrides the combinational terms).
- Recovery latency: `ex2_recover_en` sampled high in cycle t gives:
  - flushes in cycles t and t+1;
  - `redirect_en` in cycle t+1;
  - new PC valid in cycle t+2.
- A load-use hazard detected in cycle t holds ID for cycles t..t+LOAD_USE_CYCLES-1. ID advances at the edge ending cycle t+LOAD_USE_CYCLES-1.
- `hz` is re-evaluated in the first RUN cycle after LU_STALL. A persisting match stalls again.
- Reset asserted mid-LU_STALL or mid-REDIRECT returns to RUN on the next edge and drops all outputs. The pending redirect is discarded.

## Structure

- Shared core package holds:
  - the state enum `hz_state_t` (RUN=0, LU_STALL=1, REDIRECT=2);
  - `NOP_INSTR` = 32'h0;
  - the register-index width constant `REG_AW` = 5.
- One natural sub-module is `sat_counter32`: increment enable, sync active-low reset, saturating. It is instantiated twice.

## Test plan

- Reset, then `ex1_load_1`=1, `ex1_rd_1`=5, `id_rs2_2`=5 with LOAD_USE_CYCLES=2:
  - `pc_stall`/`if_id_stall`/`id_ex_bubble` are high for exactly 2 cycles;
  - `stall_cycles`=2.
- `ex1_rd_1`=0 with a load, `id_rs1_1`=0:
  - no stall;
  - all outputs stay 0.
- `ex2_recover_en`=1 with pc 0x0000_0100 in cycle t:
  - `ex1_ex2_stall`/`if_id_flush`/`id_ex_flush` high in t and t+1;
  - `redirect_en`=1 and `redirect_pc`=0x100 in t+1 only;
  - `flush_events`=1.
- Load-use stall begins in cycle t and `ex2_recover_en` arrives in t+1:
  - stall outputs drop in t+1;
  - REDIRECT in t+2;
  - no further stall cycles.
- `ex2_recover_en` held high for 3 cycles:
  - redirect in cycle 2;
  - second recovery sampled in cycle 3, giving `flush_events`=2.
- Preload `stall_cycles` near saturation through a long hazard run:
  - the count stops at 0xFFFF_FFFF;
  - `rstn`=0 for one edge clears both counters and the state.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/recovery controller: state encoding,
// architectural constants and the per-slot load-use match helper.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW    = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2
  } hz_state_t;

  // A source matches a producer only when that producer is a load writing a real register.
  function automatic logic load_use_match(input logic [REG_AW-1:0] rs,
                                          input logic              load,
                                          input logic [REG_AW-1:0] rd);
    return load && (rd != '0) && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter32.sv
// 32-bit event counter with synchronous active-low clear that sticks at all-ones.
module sat_counter32 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use hazard freeze and misprediction recovery sequencing for the
// dual-issue pipeline front end, with stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ex2_recover_en,
  input  logic [31:0]       ex2_recover_pc,
  input  logic [REG_AW-1:0] id_rs1_1,
  input  logic [REG_AW-1:0] id_rs2_1,
  input  logic [REG_AW-1:0] id_rs1_2,
  input  logic [REG_AW-1:0] id_rs2_2,
  input  logic              ex1_load_1,
  input  logic              ex1_load_2,
  input  logic [REG_AW-1:0] ex1_rd_1,
  input  logic [REG_AW-1:0] ex1_rd_2,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex1_ex2_stall,
  output logic              redirect_en,
  output logic [31:0]       redirect_pc,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
);

  localparam logic [2:0] CNT_INIT = 3'(LOAD_USE_CYCLES - 1);

  hz_state_t  state;
  logic [2:0] cnt;
  logic       hz;
  logic       hold;
  logic       flush;
  logic       enter_redirect;

  always_comb begin
    hz = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      logic              ld;
      logic [REG_AW-1:0] rd;
      ld = (k == 0) ? ex1_load_1 : ex1_load_2;
      rd = (k == 0) ? ex1_rd_1   : ex1_rd_2;
      hz = hz | load_use_match(id_rs1_1, ld, rd) | load_use_match(id_rs2_1, ld, rd)
              | load_use_match(id_rs1_2, ld, rd) | load_use_match(id_rs2_2, ld, rd);
    end
  end

  // Recovery and stall terms are combinational in RUN/LU_STALL so the flush lands in
  // the request cycle; reset masks every term, and flush always wins over hold.
  always_comb begin
    hold        = 1'b0;
    flush       = 1'b0;
    redirect_en = 1'b0;
    if (rstn) begin
      case (state)
        RUN: begin
          if (ex2_recover_en) flush = 1'b1;
          else if (hz)        hold  = 1'b1;
        end
        LU_STALL: begin
          if (ex2_recover_en) flush = 1'b1;
          else                hold  = 1'b1;
        end
        REDIRECT: begin
          flush       = 1'b1;
          redirect_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_stall      = hold;
  assign if_id_stall   = hold;
  assign id_ex_bubble  = hold;
  assign if_id_flush   = flush;
  assign id_ex_flush   = flush;
  assign ex1_ex2_stall = flush;

  assign enter_redirect = rstn && ex2_recover_en && (state != REDIRECT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= RUN;
      cnt         <= '0;
      redirect_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex2_recover_en) begin
            redirect_pc <= ex2_recover_pc;
            state       <= REDIRECT;
          end else if (hz && (LOAD_USE_CYCLES > 1)) begin
            cnt   <= CNT_INIT;
            state <= LU_STALL;
          end
        end
        LU_STALL: begin
          if (ex2_recover_en) begin
            cnt         <= '0;
            redirect_pc <= ex2_recover_pc;
            state       <= REDIRECT;
          end else begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) state <= RUN;
          end
        end
        REDIRECT: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (hold),
    .count (stall_cycles)
  );

  sat_counter32 u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (enter_redirect),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: hazard-detect vector table, directed recovery/stall
// sequences and randomized traffic against a countdown-style reference model.
module tb_hazard_ctrl;

  localparam int L = 2;

  logic        clk;
  logic        rstn;
  logic        ex2_recover_en;
  logic [31:0] ex2_recover_pc;
  logic [4:0]  id_rs1_1, id_rs2_1, id_rs1_2, id_rs2_2;
  logic        ex1_load_1, ex1_load_2;
  logic [4:0]  ex1_rd_1, ex1_rd_2;
  logic        pc_stall, if_id_stall, id_ex_bubble;
  logic        if_id_flush, id_ex_flush, ex1_ex2_stall;
  logic        redirect_en;
  logic [31:0] redirect_pc, stall_cycles, flush_events;

  hazard_ctrl #(.LOAD_USE_CYCLES(L)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .ex2_recover_en (ex2_recover_en),
    .ex2_recover_pc (ex2_recover_pc),
    .id_rs1_1       (id_rs1_1),
    .id_rs2_1       (id_rs2_1),
    .id_rs1_2       (id_rs1_2),
    .id_rs2_2       (id_rs2_2),
    .ex1_load_1     (ex1_load_1),
    .ex1_load_2     (ex1_load_2),
    .ex1_rd_1       (ex1_rd_1),
    .ex1_rd_2       (ex1_rd_2),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .id_ex_bubble   (id_ex_bubble),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex1_ex2_stall  (ex1_ex2_stall),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: cycles of forced hold still owed, a pending one-cycle redirect,
  // the last captured target and the two event totals.
  int      m_hold;
  bit      m_redir;
  logic [31:0] m_pc;
  longint  m_stalls;
  longint  m_flushes;

  typedef struct {
    logic [4:0] rs1_1, rs2_1, rs1_2, rs2_2;
    logic       ld1, ld2;
    logic [4:0] rd1, rd2;
    logic       exp_hz;
  } hz_vec_t;

  hz_vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit model_hz();
    logic [4:0] srcs[4];
    bit h = 0;
    srcs[0] = id_rs1_1; srcs[1] = id_rs2_1; srcs[2] = id_rs1_2; srcs[3] = id_rs2_2;
    foreach (srcs[i]) begin
      if (srcs[i] != 0 && ex1_load_1 && srcs[i] == ex1_rd_1) h = 1;
      if (srcs[i] != 0 && ex1_load_2 && srcs[i] == ex1_rd_2) h = 1;
    end
    return h;
  endfunction

  function automatic longint sat_inc(input longint v);
    return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction

  // 0 idle, 1 hold, 2 recovery request, 3 redirect cycle
  function automatic int model_mode();
    if (!rstn)            return 0;
    if (m_redir)          return 3;
    if (ex2_recover_en)   return 2;
    if (m_hold > 0 || model_hz()) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_redir = 0; m_pc = '0; m_stalls = 0; m_flushes = 0;
  endtask

  // Inputs are set by the caller just after a falling edge; check, clock, advance model.
  task automatic cycle();
    int mode;
    logic [6:0] exp_ctl, act_ctl;
    #1;
    mode = model_mode();
    case (mode)
      1:       exp_ctl = 7'b111_000_0;
      2:       exp_ctl = 7'b000_111_0;
      3:       exp_ctl = 7'b000_111_1;
      default: exp_ctl = 7'b000_000_0;
    endcase
    act_ctl = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush, ex1_ex2_stall, redirect_en};
    chk("controls", {57'd0, act_ctl}, {57'd0, exp_ctl});
    chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, m_pc});
    chk("counters", {stall_cycles, flush_events}, {m_stalls[31:0], m_flushes[31:0]});
    @(posedge clk);
    if (!rstn) model_reset();
    else begin
      case (mode)
        1: begin
          m_stalls = sat_inc(m_stalls);
          if (m_hold > 0) m_hold--;
          else m_hold = L - 1;
        end
        2: begin
          m_redir = 1; m_pc = ex2_recover_pc; m_hold = 0;
          m_flushes = sat_inc(m_flushes);
        end
        3: m_redir = 0;
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ex2_recover_en = 0; ex2_recover_pc = '0;
    id_rs1_1 = 0; id_rs2_1 = 0; id_rs1_2 = 0; id_rs2_2 = 0;
    ex1_load_1 = 0; ex1_load_2 = 0; ex1_rd_1 = 0; ex1_rd_2 = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rstn = 0;
    cycle();
    rstn = 1;
  endtask

  function automatic hz_vec_t mk(input logic [4:0] a, b, c, d, input logic l1, l2,
                                 input logic [4:0] r1, r2, input logic e);
    hz_vec_t v;
    v.rs1_1 = a; v.rs2_1 = b; v.rs1_2 = c; v.rs2_2 = d;
    v.ld1 = l1; v.ld2 = l2; v.rd1 = r1; v.rd2 = r2; v.exp_hz = e;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(7, 0, 0, 0, 1, 0, 7, 0, 1);
    vecs[1] = mk(0, 3, 0, 0, 0, 1, 0, 3, 1);
    vecs[2] = mk(0, 0, 9, 0, 0, 0, 9, 9, 0);
    vecs[3] = mk(0, 0, 0, 4, 1, 0, 4, 0, 1);
    vecs[4] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[5] = mk(6, 1, 0, 0, 1, 1, 2, 6, 1);
    vecs[6] = mk(8, 8, 8, 8, 1, 0, 9, 8, 0);
    vecs[7] = mk(31, 0, 0, 0, 0, 1, 5, 31, 1);

    clear_inputs();
    rstn = 0;
    model_reset();
    @(negedge clk);

    // Reset overrides live recovery and hazard inputs
    ex2_recover_en = 1; ex1_load_1 = 1; ex1_rd_1 = 5; id_rs1_1 = 5;
    #1;
    chk("reset_ctl", {pc_stall, if_id_flush, ex1_ex2_stall, redirect_en}, 4'b0000);
    cycle();
    chk("reset_regs", {redirect_pc, stall_cycles, flush_events}, 96'd0);
    clear_inputs();
    rstn = 1;

    // Load-use: slot-2 rs2 vs slot-1 load rd, held exactly L cycles
    ex1_load_1 = 1; ex1_rd_1 = 5; id_rs2_2 = 5;
    #1; chk("lu_t0", {pc_stall, if_id_stall, id_ex_bubble}, 3'b111); cycle();
    #1; chk("lu_t1", {pc_stall, if_id_stall, id_ex_bubble}, 3'b111); cycle();
    clear_inputs();
    #1; chk("lu_t2", {pc_stall, if_id_stall, id_ex_bubble}, 3'b000);
    chk("lu_count", stall_cycles, 2); cycle();

    // Load to x0 never stalls
    ex1_load_1 = 1; ex1_rd_1 = 0; id_rs1_1 = 0;
    #1; chk("x0_quiet", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush,
                         ex1_ex2_stall, redirect_en}, 7'd0);
    cycle();

    // Recovery latency
    reset_dut();
    ex2_recover_en = 1; ex2_recover_pc = 32'h0000_0100;
    #1; chk("rec_t0", {if_id_flush, id_ex_flush, ex1_ex2_stall, redirect_en}, 4'b1110); cycle();
    clear_inputs();
    #1; chk("rec_t1", {if_id_flush, id_ex_flush, ex1_ex2_stall, redirect_en}, 4'b1111);
    chk("rec_pc", redirect_pc, 32'h100); cycle();
    #1; chk("rec_t2", {if_id_flush, redirect_en}, 2'b00);
    chk("rec_pc_hold", redirect_pc, 32'h100);
    chk("rec_events", flush_events, 1); cycle();

    // Recovery preempting a load-use stall
    reset_dut();
    ex1_load_2 = 1; ex1_rd_2 = 12; id_rs1_1 = 12;
    #1; chk("pre_t0", {pc_stall, if_id_flush}, 2'b10); cycle();
    ex2_recover_en = 1; ex2_recover_pc = 32'hDEAD_BEE0;
    #1; chk("pre_t1", {pc_stall, if_id_flush}, 2'b01); cycle();
    ex2_recover_en = 0;
    #1; chk("pre_t2", {pc_stall, redirect_en}, 2'b01);
    chk("pre_pc", redirect_pc, 32'hDEAD_BEE0); cycle();
    clear_inputs();
    #1; chk("pre_stalls", stall_cycles, 1); cycle();

    // Recovery request held three cycles
    reset_dut();
    ex2_recover_en = 1; ex2_recover_pc = 32'h2000;
    #1; chk("held_c1", redirect_en, 0); cycle();
    ex2_recover_pc = 32'h3000;
    #1; chk("held_c2", {redirect_en, redirect_pc}, {1'b1, 32'h2000}); cycle();
    ex2_recover_pc = 32'h4000;
    #1; chk("held_c3", {redirect_en, if_id_flush}, 2'b01); cycle();
    clear_inputs();
    #1; chk("held_c4", {redirect_en, redirect_pc}, {1'b1, 32'h4000});
    chk("held_events", flush_events, 2); cycle();

    // Hazard detection table
    foreach (vecs[i]) begin
      reset_dut();
      id_rs1_1 = vecs[i].rs1_1; id_rs2_1 = vecs[i].rs2_1;
      id_rs1_2 = vecs[i].rs1_2; id_rs2_2 = vecs[i].rs2_2;
      ex1_load_1 = vecs[i].ld1; ex1_load_2 = vecs[i].ld2;
      ex1_rd_1 = vecs[i].rd1;   ex1_rd_2 = vecs[i].rd2;
      #1; chk($sformatf("hz_vec%0d", i), pc_stall, vecs[i].exp_hz);
      cycle();
    end

    // Counter saturation and clear
    reset_dut();
    dut.u_stall_cnt.count = 32'hFFFF_FFFD;
    m_stalls = 64'hFFFF_FFFD;
    ex1_load_1 = 1; ex1_rd_1 = 3; id_rs1_2 = 3;
    repeat (6) cycle();
    clear_inputs();
    #1; chk("sat_top", stall_cycles, 32'hFFFF_FFFF); cycle();
    ex2_recover_en = 1; ex2_recover_pc = 32'h44;
    cycle();
    rstn = 0; clear_inputs(); cycle(); rstn = 1;
    #1; chk("sat_clear", {stall_cycles, flush_events, redirect_pc}, 96'd0);
    chk("sat_clear_ctl", {pc_stall, if_id_flush, redirect_en}, 3'b000);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      rstn           = ($urandom_range(0, 59) != 0);
      ex2_recover_en = ($urandom_range(0, 7) == 0);
      ex2_recover_pc = $urandom;
      id_rs1_1 = 5'($urandom_range(0, 3)); id_rs2_1 = 5'($urandom_range(0, 3));
      id_rs1_2 = 5'($urandom_range(0, 3)); id_rs2_2 = 5'($urandom_range(0, 3));
      ex1_load_1 = ($urandom_range(0, 2) == 0); ex1_load_2 = ($urandom_range(0, 2) == 0);
      ex1_rd_1 = 5'($urandom_range(0, 5)); ex1_rd_2 = 5'($urandom_range(0, 5));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
